// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- definitions shared by the instruction fetch unit and the
// instruction-memory loader.
//   IMEM_ADDR_W / IMEM_DATA_W : default word-address and word widths
//   IMEM_DEPTH                : number of instruction words
//   imem_state_e              : loader FSM state encoding
//   len_is_legal()            : word-count range check for a load request
package imem_loader_pkg;

   localparam int IMEM_ADDR_W = 8;
   localparam int IMEM_DATA_W = 32;
   localparam int IMEM_DEPTH  = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } imem_state_e;

   // A load must cover at least one word and must not exceed the memory depth.
   function automatic logic len_is_legal(input int unsigned len, input int unsigned depth);
      return (len >= 32'd1) && (len <= depth);
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer -- assembles a big-endian instruction word from a byte stream.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : drop any partial word and restart at the first byte
//   shift_en   : a byte is accepted this cycle
//   byte_in    : accepted byte
//   word       : assembled word (first byte ends up in the most significant byte)
//   last_byte  : the byte accepted this cycle completes the word
module imem_word_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word,
   output logic              last_byte
);

   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        cnt_q, cnt_d;

   // Shift each new byte in at the bottom so earlier bytes migrate toward the MSB.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         word_d = {DATA_W{1'b0}};
         cnt_d  = 2'd0;
      end else if (shift_en) begin
         word_d = {word_q[DATA_W-9:0], byte_in};
         cnt_d  = cnt_q + 2'd1;
      end else begin
         word_d = word_q;
         cnt_d  = cnt_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= {DATA_W{1'b0}};
         cnt_q  <= 2'd0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word      = word_q;
   // The byte counter wraps to zero on its own once the word is full.
   assign last_byte = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- streams a program byte stream into instruction memory while
// holding the CPU fetch unit.
//   start/len_words : begin a load of len_words words (1..2**ADDR_W)
//   abort           : cancel an active load (reported on error)
//   byte_data/valid/ready : byte stream handshake, big-endian within a word
//   mem_we/addr/wdata     : one write strobe per assembled word
//   cpu_hold, busy  : asserted whenever the loader is not idle
//   done, error     : one-cycle completion / failure pulses
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic              abort,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   imem_state_e       state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic              error_q, error_d;

   logic              pk_clear_s;
   logic              pk_shift_s;
   logic              pk_last_s;
   logic [DATA_W-1:0] pk_word_s;
   logic              last_word_s;

   imem_word_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pk_clear_s),
      .shift_en  (pk_shift_s),
      .byte_in   (byte_data),
      .word      (pk_word_s),
      .last_byte (pk_last_s)
   );

   // Comparing against len-1 keeps the word counter inside ADDR_W bits, so a
   // full-depth load ends at the top address instead of wrapping.
   assign last_word_s = ({1'b0, wcnt_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));

   // Next-state, counter and packer-control logic; abort takes priority over
   // any byte accepted in the same cycle.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wcnt_d     = wcnt_q;
      error_d    = 1'b0;
      pk_clear_s = 1'b0;
      pk_shift_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len_is_legal(32'(len_words), DEPTH)) begin
                  len_d      = len_words;
                  wcnt_d     = {ADDR_W{1'b0}};
                  pk_clear_s = 1'b1;
                  state_d    = ST_LOAD;
               end else begin
                  error_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               error_d    = 1'b1;
               pk_clear_s = 1'b1;
               state_d    = ST_IDLE;
            end else if (byte_valid) begin
               pk_shift_s = 1'b1;
               if (pk_last_s) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               error_d    = 1'b1;
               pk_clear_s = 1'b1;
               state_d    = ST_IDLE;
            end else if (last_word_s) begin
               state_d = ST_DONE;
            end else begin
               wcnt_d  = wcnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Loader state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         len_q   <= {(ADDR_W+1){1'b0}};
         wcnt_q  <= {ADDR_W{1'b0}};
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         error_q <= error_d;
      end
   end

   // Outputs decode the registered state; reset masks them in the reset cycle
   // itself, and abort cancels the write strobe of the cycle it arrives in.
   assign byte_ready = !reset && (state_q == ST_LOAD);
   assign mem_we     = !reset && !abort && (state_q == ST_WRITE);
   assign mem_addr   = reset ? {ADDR_W{1'b0}} : wcnt_q;
   assign mem_wdata  = reset ? {DATA_W{1'b0}} : pk_word_s;
   assign busy       = !reset && (state_q != ST_IDLE);
   assign cpu_hold   = busy;
   assign done       = !reset && (state_q == ST_DONE);
   assign error      = !reset && error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- randomized scoreboard bench for imem_loader. A driver
// issues loads and pushes the words the reference model predicts; a monitor
// pops and compares on every mem_we.
module tb_imem_loader;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len_words = '0;
   logic          abort = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_valid = 1'b0;
   logic          byte_ready, mem_we, cpu_hold, busy, done, error;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [AW-1:0] last_addr = '0;
   logic [AW+DW-1:0] exp_q[$];
   logic [7:0] t1_bytes[4] = '{8'h20, 8'h11, 8'h00, 8'h05};

   imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len_words  (len_words),
      .abort      (abort),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_ready"}, byte_ready, 1'b0);
      check({tag, "_mem_we"},     mem_we,     1'b0);
      check({tag, "_cpu_hold"},   cpu_hold,   1'b0);
      check({tag, "_busy"},       busy,       1'b0);
      check({tag, "_done"},       done,       1'b0);
      check({tag, "_error"},      error,      1'b0);
      check({tag, "_mem_addr"},   mem_addr,   '0);
      check({tag, "_mem_wdata"},  mem_wdata,  '0);
   endtask

   // Monitor: scoreboard pop on writes, pulse counting and hold/busy agreement.
   initial begin : monitor
      logic prev_we;
      logic [AW+DW-1:0] e;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            check("we_single_cycle", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: addr %0h data %0h while none required", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", mem_addr, e[AW+DW-1:DW]);
               check("write_data", mem_wdata, e[DW-1:0]);
            end
            last_addr = mem_addr;
         end
         if (done) begin
            done_cnt++;
            check("done_after_write", prev_we, 1'b1);
            check("hold_at_done", cpu_hold, 1'b1);
         end
         if (error) err_cnt++;
         check("hold_eq_busy", cpu_hold, busy);
         prev_we = mem_we;
      end
   end

   // One load: the model predicts one word per four accepted bytes (MSB-first),
   // no word for bytes cut off by abort, done on success, error on abort.
   task automatic do_load(input int len, input int abort_at, input bit abort_on_byte,
                          input int gap_pct, input int mode, input bit poke_start);
      logic [7:0] bytes[$];
      logic [7:0] b;
      int total, n_send, nwords, idx, cyc, d0, e0, budget;
      bit poked;
      total  = 4 * len;
      budget = 20 * total + 100;
      for (int i = 0; i < total; i++) begin
         case (mode)
            1:       b = 8'(i);
            2:       b = t1_bytes[i % 4];
            default: b = 8'($urandom);
         endcase
         bytes.push_back(b);
      end
      n_send = (abort_at >= 0) ? abort_at : total;
      nwords = (abort_at >= 0) ? abort_at / 4 : len;
      for (int k = 0; k < nwords; k++)
         exp_q.push_back({8'(k), bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]});
      d0 = done_cnt;
      e0 = err_cnt;

      start = 1'b1;
      len_words = 9'(len);
      @(posedge clk); #1;
      start = 1'b0;
      len_words = '0;
      check("hold_on_load_entry", cpu_hold, 1'b1);
      check("busy_on_load_entry", busy, 1'b1);

      idx = 0; cyc = 0; poked = 1'b0;
      while (idx < n_send && cyc < budget) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            byte_valid = 1'b0;
         end else begin
            byte_valid = 1'b1;
            byte_data  = bytes[idx];
         end
         if (poke_start && !poked && idx >= total / 2) begin
            start = 1'b1;
            len_words = 9'd3;
            poked = 1'b1;
         end
         @(negedge clk);
         if (byte_valid && byte_ready) idx++;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      byte_valid = 1'b0;
      check("bytes_within_budget", cyc < budget, 1'b1);

      if (abort_at >= 0) begin
         cyc = 0;
         @(negedge clk);
         while (!byte_ready && cyc < budget) begin
            @(negedge clk);
            cyc++;
         end
         check("abort_ready_within_budget", cyc < budget, 1'b1);
         abort = 1'b1;
         if (abort_on_byte) begin
            byte_valid = 1'b1;
            byte_data  = bytes[idx];
         end
         @(posedge clk); #1;
         abort = 1'b0;
         byte_valid = 1'b0;
      end

      cyc = 0;
      while (busy && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("idle_within_budget", cyc < budget, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - d0, (abort_at < 0) ? 1 : 0);
      check("error_pulses", err_cnt - e0, (abort_at >= 0) ? 1 : 0);
      check("writes_drained", exp_q.size(), 0);
      check("idle_after_load", busy, 1'b0);
   endtask

   // Illegal length: one error pulse the next cycle, never leaves IDLE.
   task automatic bad_start(input logic [AW:0] len);
      int e0;
      e0 = err_cnt;
      start = 1'b1;
      len_words = len;
      @(posedge clk); #1;
      start = 1'b0;
      len_words = '0;
      check("bad_len_error", error, 1'b1);
      check("bad_len_busy", busy, 1'b0);
      @(posedge clk); #1;
      check("bad_len_error_one_cycle", error, 1'b0);
      check("bad_len_still_idle", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("bad_len_error_count", err_cnt - e0, 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int len, ab;
      bit on_byte;

      // Reset state, both during reset and on the cycle after release.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("in_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      check_all_zero("after_reset");
      @(posedge clk); #1;

      // Directed: single word 0x20110005, back-to-back bytes.
      do_load(1, -1, 1'b0, 0, 2, 1'b0);
      // Directed: three words with random gaps.
      do_load(3, -1, 1'b0, 40, 0, 1'b0);
      // Directed: illegal lengths.
      bad_start(9'd0);
      bad_start(9'd257);
      bad_start(9'd511);
      // Directed: abort after six bytes, then abort coinciding with a 4th byte.
      do_load(2, 6, 1'b0, 0, 0, 1'b0);
      do_load(2, 7, 1'b1, 0, 0, 1'b0);
      // Abort right at a word boundary and before any byte.
      do_load(3, 8, 1'b0, 20, 0, 1'b0);
      do_load(2, 0, 1'b0, 0, 0, 1'b0);

      // Directed: reset on the cycle the 4th byte is accepted.
      start = 1'b1;
      len_words = 9'd1;
      @(posedge clk); #1;
      start = 1'b0;
      len_words = '0;
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'(8'hA0 + i);
         @(posedge clk); #1;
      end
      byte_data = 8'hA3;
      reset = 1'b1;
      @(negedge clk);
      check("reset_4th_byte_no_we", mem_we, 1'b0);
      check("reset_4th_byte_no_ready", byte_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      byte_valid = 1'b0;
      check_all_zero("post_reset");
      repeat (3) @(posedge clk);
      #1;
      check("reset_no_writes_pending", exp_q.size(), 0);

      // Randomized loads, some with aborts.
      for (int t = 0; t < 10; t++) begin
         len = int'($urandom_range(1, 6));
         ab  = ($urandom_range(2) == 0) ? int'($urandom_range(4 * len - 1)) : -1;
         on_byte = (ab >= 0) && ($urandom_range(1) == 1);
         do_load(len, ab, on_byte, int'($urandom_range(60)), 0, 1'b0);
      end

      // Directed: full depth, incrementing data, start poked mid-load.
      do_load(256, -1, 1'b0, 0, 1, 1'b1);
      check("last_addr_no_wrap", last_addr, 8'hFF);

      // Loader still usable after the full-depth load.
      do_load(1, -1, 1'b0, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 8, meaning instruction-memory word-address width (256 words).
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a load.
REQ-006 The block SHALL have port len_words, input, ADDR_W+1 bits, meaning the word count, sampled with start; legal range 1..256.
REQ-007 The block SHALL have port abort, input, 1 bit, meaning cancel an active load.
REQ-008 The block SHALL have port byte_data, input, 8 bits, meaning the program byte stream, big-endian within each word.
REQ-009 The block SHALL have port byte_valid, input, 1 bit, meaning byte_data is valid.
REQ-010 The block SHALL have port byte_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-011 The block SHALL have port mem_we, output, 1 bit, meaning the instruction-memory write strobe.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits, meaning the word write address.
REQ-013 The block SHALL have port mem_wdata, output, DATA_W bits, meaning the word write data.
REQ-014 The block SHALL have port cpu_hold, output, 1 bit, meaning hold the fetch unit/PC while loading.
REQ-015 The block SHALL have port busy, output, 1 bit, meaning state != IDLE.
REQ-016 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse on successful completion.
REQ-017 The block SHALL have port error, output, 1 bit, meaning a one-cycle pulse on illegal len_words or abort.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-019 In IDLE, start with 1<=len_words<=256 SHALL latch len_words, clear the word and byte counters, and go to LOAD next cycle.
REQ-020 In IDLE, start with len_words=0 or >256 SHALL pulse error the next cycle and remain in IDLE.
REQ-021 A byte SHALL transfer only on byte_valid && byte_ready; byte_ready SHALL be 1 only in LOAD.
REQ-022 Accepted bytes SHALL fill the word MSB-first: 1st byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-023 Acceptance of the 4th byte SHALL move the FSM to WRITE; mem_we SHALL be 1 for exactly that one WRITE cycle, with mem_addr = word counter and mem_wdata = the assembled word.
REQ-024 From WRITE, if word counter = len-1 the FSM SHALL go to DONE; otherwise the counter SHALL increment and the FSM SHALL return to LOAD.
REQ-025 The counter SHALL never wrap: len=256 SHALL write addresses 0..255 and then finish.
REQ-026 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-027 cpu_hold SHALL be 1 in LOAD, WRITE and DONE, and 0 in IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in LOAD or WRITE SHALL go to IDLE next cycle, pulse error, suppress any pending mem_we, and discard the partial word.
REQ-030 If abort and the 4th byte acceptance coincide, abort SHALL win and no write SHALL occur.
REQ-031 Best-case throughput SHALL be 5 cycles per word (4 accept + 1 write); byte_valid gaps SHALL only stretch LOAD.

Reset
REQ-032 reset SHALL override all other inputs, including mid-load, and force IDLE with no write issued in that cycle.
REQ-033 While reset is asserted and on the cycle after, byte_ready, mem_we, cpu_hold, busy, done and error SHALL be 0, and mem_addr, mem_wdata, the counters and the latched length SHALL be 0.

Structure
REQ-034 The state encoding, ADDR_W/DATA_W defaults and IMEM_DEPTH=256 SHALL live in a shared package used by both fetch and loader.
REQ-035 The block SHALL contain one sub-module, imem_word_packer (byte shift register and 2-bit byte counter), instantiated once.

Verification
REQ-036 Test 1: start with len=1, bytes 20,11,00,05 back-to-back -> one mem_we at addr 0 with data 0x20110005, then done on the cycle after the write.
REQ-037 Test 2: len=3 with random valid gaps -> writes to addrs 0,1,2 in order, each 1 cycle wide, and cpu_hold high from LOAD entry through DONE.
REQ-038 Test 3: start with len=0, and separately len=257 -> error pulse, busy stays 0, no mem_we.
REQ-039 Test 4: len=2 with abort after 6 bytes -> error pulse, exactly one write (addr 0), then IDLE.
REQ-040 Test 5: reset asserted on the cycle the 4th byte is accepted -> no mem_we, and all outputs 0 the next cycle.
REQ-041 Test 6: len=256 with incrementing data -> last write at addr 0xFF with no wrap, and start pulsed mid-load is ignored.
